ysyx_22041211_mem_arbiter: RTL and testbench
============================================

Name: ysyx_22041211_mem_arbiter

Overview:
Shares the single DPI-backed data-memory port between two requesters: the IFU (read-only fetch) and the LSU (load/store).
- Round-robin arbitration; one outstanding transaction at a time.
- Handshakes are valid/ready; a watchdog timeout returns an error on a hung memory.
- Sits between the pipeline stages and the memory model, replacing direct per-stage memory task calls.

Parameters:
DATA_LEN, 32, data/address width
MASK_W, 8, byte-mask width (matches the memory task mask argument)
TIMEOUT, 255, max cycles in REQ+WAIT before abort; counter width clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
ifu_req_valid  in  1  fetch request
ifu_req_ready  out  1  arbiter accepts fetch
ifu_addr  in  DATA_LEN  fetch address
ifu_rsp_valid  out  1  fetch response, 1-cycle pulse
ifu_rdata  out  DATA_LEN  fetch data
ifu_rsp_err  out  1  fetch timed out
lsu_req_valid  in  1  load/store request
lsu_req_ready  out  1  arbiter accepts LSU
lsu_addr  in  DATA_LEN  address
lsu_wen  in  1  1=store, 0=load
lsu_wdata  in  DATA_LEN  store data
lsu_mask  in  MASK_W  byte mask
lsu_rsp_valid  out  1  LSU response, 1-cycle pulse
lsu_rdata  out  DATA_LEN  load data (0 for stores)
lsu_rsp_err  out  1  LSU timed out
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts
mem_addr  out  DATA_LEN  latched address
mem_wen  out  1  latched write enable
mem_wdata  out  DATA_LEN  latched store data
mem_mask  out  MASK_W  latched mask
mem_rsp_valid  in  1  memory response
mem_rdata  in  DATA_LEN  memory data
mem_abort  out  1  1-cycle pulse: drop outstanding request

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset value: IDLE; all outputs 0; last_grant=IFU; timeout counter=0.
- IDLE:
  - Ready is combinational and goes only to the chosen requester.
  - Only one valid: that requester is chosen.
  - Both valid: choose the one not equal to last_grant. After reset, LSU wins the first conflict.
  - On handshake: latch addr/wen/wdata/mask and owner; update last_grant; counter=0; go REQ.
- IFU requests are issued as wen=0, mask=8'h0F (32-bit load).
- REQ:
  - mem_req_valid=1 with latched fields, held stable until mem_req_ready.
  - On handshake: go WAIT.
  - Zero-wait memory (mem_rsp_valid in the same cycle as mem_req_ready) is legal: go directly to RESP.
- WAIT: on mem_rsp_valid, register mem_rdata (forced to 0 if wen=1) and go RESP.
- RESP:
  - Owner's rsp_valid=1 for exactly one cycle; the other requester's rsp_valid stays 0.
  - Then go IDLE.
  - Both ready outputs are 0 in REQ, WAIT and RESP.
  - Minimum latency: request handshake to rsp_valid is 2 cycles (zero-wait memory).
- rdata outputs hold their last value until the next response to the same requester.
- mem_rsp_valid outside WAIT (or outside the REQ zero-wait case) is ignored.
- Timeout:
  - Counter increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT without completion: mem_abort=1 for one cycle, mem_req_valid=0, go RESP with err=1 and rdata=0.
  - err is 0 on normal completion.
  - A mem_rsp_valid arriving in the abort cycle is discarded.
- Requesters must hold valid and payload until ready. A requester dropping valid before ready is not an error; that requester is simply not granted.
- rst mid-transaction: next cycle IDLE, no response emitted, mem_req_valid=0, no abort pulse.

Decomposition:
- Shared define file: FSM state encodings, OWNER_IFU/OWNER_LSU, LOAD_MASK_32 (reuse existing mask constants).
- Sub-module ysyx_22041211_rr_pick2: inputs two valids and last_grant; outputs one-hot grant. Purely combinational, reusable for future masters.

Test Plan:
- Only IFU valid, addr=0x80000000; memory ready at once, rsp one cycle later with 0x00000413 -> ifu_rsp_valid pulse carrying 0x00000413, err=0, lsu_rsp_valid stays 0.
- Both valid continuously after reset -> grants in order LSU, IFU, LSU, IFU; each response goes only to its owner.
- LSU store addr=0x80001000, wdata=0xDEADBEEF, mask=0x0F; memory holds ready low 3 cycles -> mem fields stable all 3 cycles, lsu_rsp_valid pulse with rdata=0.
- Memory never responds, TIMEOUT=8 -> mem_abort pulse at counter==8, lsu_rsp_err=1, rdata=0; arbiter returns to IDLE and accepts the next request.
- rst asserted in WAIT -> next cycle IDLE, all outputs 0; a late mem_rsp_valid produces no response.
- Zero-wait memory (ready and rsp_valid in the same cycle) -> response exactly 2 cycles after the request handshake.

Source files
------------

// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041211_mem_arbiter_pkg
// Description : Shared definitions for the data-memory arbiter: FSM state
//               encoding, transaction owner codes and the fixed fetch mask.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041211_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Owner codes double as the round-robin history value.
    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    // Grant vector bit positions used by the two-way picker.
    localparam int GRANT_IFU_BIT = 0;
    localparam int GRANT_LSU_BIT = 1;

    // Byte mask the memory task expects for a full 32-bit load.
    localparam logic [7:0] LOAD_MASK_32 = 8'h0F;

endpackage : ysyx_22041211_mem_arbiter_pkg
`default_nettype wire

// File: rtl/ysyx_22041211_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041211_mem_arbiter_if
// Description : Bus bundle around the data-memory arbiter.
//               IFU side : ifu_req_valid/ready, ifu_addr, ifu_rsp_valid,
//                          ifu_rdata, ifu_rsp_err
//               LSU side : lsu_req_valid/ready, lsu_addr, lsu_wen,
//                          lsu_wdata, lsu_mask, lsu_rsp_valid, lsu_rdata,
//                          lsu_rsp_err
//               Memory   : mem_req_valid/ready, mem_addr, mem_wen,
//                          mem_wdata, mem_mask, mem_rsp_valid, mem_rdata,
//                          mem_abort
//               slave  modport : the arbiter
//               master modport : requesters plus memory model
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22041211_mem_arbiter_if #(
    parameter int DATA_LEN = 32,
    parameter int MASK_W   = 8
);
    logic                ifu_req_valid;
    logic                ifu_req_ready;
    logic [DATA_LEN-1:0] ifu_addr;
    logic                ifu_rsp_valid;
    logic [DATA_LEN-1:0] ifu_rdata;
    logic                ifu_rsp_err;

    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic [DATA_LEN-1:0] lsu_addr;
    logic                lsu_wen;
    logic [DATA_LEN-1:0] lsu_wdata;
    logic [MASK_W-1:0]   lsu_mask;
    logic                lsu_rsp_valid;
    logic [DATA_LEN-1:0] lsu_rdata;
    logic                lsu_rsp_err;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [DATA_LEN-1:0] mem_addr;
    logic                mem_wen;
    logic [DATA_LEN-1:0] mem_wdata;
    logic [MASK_W-1:0]   mem_mask;
    logic                mem_rsp_valid;
    logic [DATA_LEN-1:0] mem_rdata;
    logic                mem_abort;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_mask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_mask, mem_abort
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_mask,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_mask, mem_abort
    );

endinterface : ysyx_22041211_mem_arbiter_if
`default_nettype wire

// File: rtl/ysyx_22041211_mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041211_rr_pick2
// Description : Two-way round-robin picker, purely combinational.
//               i_valid      : request valids (bit0 IFU, bit1 LSU)
//               i_last_grant : owner code of the previous grant
//               o_grant      : one-hot grant, zero when nothing is valid
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041211_rr_pick2
    import ysyx_22041211_mem_arbiter_pkg::*;
(
    input  wire logic [1:0] i_valid,
    input  wire logic       i_last_grant,
    output logic      [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant[GRANT_IFU_BIT] = 1'b1;
            2'b10:   o_grant[GRANT_LSU_BIT] = 1'b1;
            // Conflict: the side that did not win last time goes next.
            2'b11: begin
                if (i_last_grant == OWNER_IFU) begin
                    o_grant[GRANT_LSU_BIT] = 1'b1;
                end else begin
                    o_grant[GRANT_IFU_BIT] = 1'b1;
                end
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule : ysyx_22041211_rr_pick2
`default_nettype wire

// File: rtl/ysyx_22041211_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041211_mem_arbiter
// Description : Shares one data-memory port between the IFU (fetch) and the
//               LSU (load/store). Round-robin, one transaction in flight,
//               valid/ready handshakes, watchdog abort on a hung memory.
//               clk : clock
//               rst : synchronous active-high reset
//               bus : requester and memory signals (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041211_mem_arbiter
    import ysyx_22041211_mem_arbiter_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int MASK_W   = 8,
    parameter int TIMEOUT  = 255
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ysyx_22041211_mem_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                r_last_grant;
    logic [DATA_LEN-1:0] r_addr;
    logic                r_wen;
    logic [DATA_LEN-1:0] r_wdata;
    logic [MASK_W-1:0]   r_mask;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic [DATA_LEN-1:0] r_ifu_rdata;
    logic [DATA_LEN-1:0] r_lsu_rdata;

    logic [1:0]          w_grant;
    logic                w_accept;
    logic                w_busy;
    logic                w_timeout;
    logic                w_done;
    logic [DATA_LEN-1:0] w_rsp_data;

    ysyx_22041211_rr_pick2 u_pick (
        .i_valid      ({bus.lsu_req_valid, bus.ifu_req_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Nothing is accepted while reset is held, so a request presented
    // during reset cannot slip through the handshake.
    assign w_accept  = (r_state == ST_IDLE) && !rst && (w_grant != 2'b00);
    assign w_busy    = (r_state == ST_REQ) || (r_state == ST_WAIT);
    // The watchdog wins over a response landing in the same cycle.
    assign w_timeout = w_busy && (r_cnt == CNT_W'(TIMEOUT));
    assign w_done    = !w_timeout &&
                       (((r_state == ST_REQ) && bus.mem_req_ready && bus.mem_rsp_valid) ||
                        ((r_state == ST_WAIT) && bus.mem_rsp_valid));
    assign w_rsp_data = (w_timeout || r_wen) ? '0 : bus.mem_rdata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (w_timeout || w_done) begin
                    w_state_nxt = ST_RESP;
                end else if (bus.mem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: if (w_timeout || w_done) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWNER_IFU;
            r_last_grant <= OWNER_IFU;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_ifu_rdata  <= '0;
            r_lsu_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner      <= w_grant[GRANT_LSU_BIT];
                r_last_grant <= w_grant[GRANT_LSU_BIT];
                r_cnt        <= '0;
                if (w_grant[GRANT_LSU_BIT]) begin
                    r_addr  <= bus.lsu_addr;
                    r_wen   <= bus.lsu_wen;
                    r_wdata <= bus.lsu_wdata;
                    r_mask  <= bus.lsu_mask;
                end else begin
                    // Fetches are always plain 32-bit loads.
                    r_addr  <= bus.ifu_addr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                    r_mask  <= MASK_W'(LOAD_MASK_32);
                end
            end else if (w_busy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done || w_timeout) begin
                r_err <= w_timeout;
                if (r_owner == OWNER_LSU) begin
                    r_lsu_rdata <= w_rsp_data;
                end else begin
                    r_ifu_rdata <= w_rsp_data;
                end
            end
        end
    end

    assign bus.ifu_req_ready = w_accept && w_grant[GRANT_IFU_BIT];
    assign bus.lsu_req_ready = w_accept && w_grant[GRANT_LSU_BIT];

    assign bus.ifu_rsp_valid = (r_state == ST_RESP) && (r_owner == OWNER_IFU);
    assign bus.lsu_rsp_valid = (r_state == ST_RESP) && (r_owner == OWNER_LSU);
    assign bus.ifu_rsp_err   = bus.ifu_rsp_valid && r_err;
    assign bus.lsu_rsp_err   = bus.lsu_rsp_valid && r_err;
    assign bus.ifu_rdata     = r_ifu_rdata;
    assign bus.lsu_rdata     = r_lsu_rdata;

    // The request is withdrawn in the abort cycle.
    assign bus.mem_req_valid = (r_state == ST_REQ) && !w_timeout;
    assign bus.mem_abort     = w_timeout;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wen       = r_wen;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_mask      = r_mask;

endmodule : ysyx_22041211_mem_arbiter
`default_nettype wire

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22041211_mem_arbiter
// Description : Self-checking bench for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041211_mem_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_ifu_rdata;
    logic [31:0] exp_lsu_rdata;

    ysyx_22041211_mem_arbiter_if #(.DATA_LEN(32), .MASK_W(8)) bus ();

    ysyx_22041211_mem_arbiter #(
        .DATA_LEN (32),
        .MASK_W   (8),
        .TIMEOUT  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        string       name;
        logic        is_lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [7:0]  mask;
        int          mem_delay;
        int          rsp_delay;
        logic [31:0] mdata;
        logic [31:0] exp_rdata;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_mask;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic is_lsu, input logic [31:0] addr,
                                input logic wen, input logic [31:0] wdata, input logic [7:0] mask,
                                input int md, input int rd, input logic [31:0] mdata,
                                input logic [31:0] er, input logic ew, input logic [31:0] ewd,
                                input logic [7:0] em);
        vec_t v;
        v.name = nm; v.is_lsu = is_lsu; v.addr = addr; v.wen = wen; v.wdata = wdata;
        v.mask = mask; v.mem_delay = md; v.rsp_delay = rd; v.mdata = mdata;
        v.exp_rdata = er; v.exp_wen = ew; v.exp_wdata = ewd; v.exp_mask = em;
        return v;
    endfunction

    task automatic check_mem_fields(input vec_t v, input string tag);
        check({v.name, "_", tag, "_reqv"}, 64'(bus.mem_req_valid), 64'h1);
        check({v.name, "_", tag, "_fields"},
              {bus.mem_addr, bus.mem_wdata},
              {v.addr, v.exp_wdata});
        check({v.name, "_", tag, "_wen_mask"},
              64'({bus.mem_wen, bus.mem_mask}), 64'({v.exp_wen, v.exp_mask}));
    endtask

    // One complete transaction from a single requester.
    task automatic do_txn(input vec_t v);
        @(negedge clk);
        if (v.is_lsu) begin
            bus.lsu_req_valid = 1'b1; bus.lsu_addr = v.addr; bus.lsu_wen = v.wen;
            bus.lsu_wdata = v.wdata; bus.lsu_mask = v.mask;
        end else begin
            bus.ifu_req_valid = 1'b1; bus.ifu_addr = v.addr;
        end
        #1 check({v.name, "_ready"}, 64'({bus.lsu_req_ready, bus.ifu_req_ready}),
                 v.is_lsu ? 64'h2 : 64'h1);
        @(negedge clk);
        bus.lsu_req_valid = 1'b0;
        bus.ifu_req_valid = 1'b0;
        for (int d = 0; d < v.mem_delay; d++) begin
            #1 check_mem_fields(v, "stall");
            @(negedge clk);
        end
        bus.mem_req_ready = 1'b1;
        if (v.rsp_delay == 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = v.mdata;
        end
        #1 check_mem_fields(v, "hs");
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        if (v.rsp_delay > 0) begin
            repeat (v.rsp_delay - 1) @(negedge clk);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = v.mdata;
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
        end
        if (v.is_lsu) exp_lsu_rdata = v.exp_rdata;
        else          exp_ifu_rdata = v.exp_rdata;
        #1;
        check({v.name, "_rsp_valid"}, 64'({bus.lsu_rsp_valid, bus.ifu_rsp_valid}),
              v.is_lsu ? 64'h2 : 64'h1);
        check({v.name, "_rdata"}, {bus.ifu_rdata, bus.lsu_rdata}, {exp_ifu_rdata, exp_lsu_rdata});
        check({v.name, "_err"}, 64'({bus.lsu_rsp_err, bus.ifu_rsp_err}), 64'h0);
        @(negedge clk);
        #1 check({v.name, "_rsp_pulse"}, 64'({bus.lsu_rsp_valid, bus.ifu_rsp_valid}), 64'h0);
    endtask

    vec_t vecs[4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_ifu_rdata = '0;
        exp_lsu_rdata = '0;
        vecs[0] = mk("ifu_fetch", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 0, 1,
                     32'h0000_0413, 32'h0000_0413, 1'b0, 32'h0, 8'h0F);
        vecs[1] = mk("lsu_store", 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 3, 1,
                     32'h1234_5678, 32'h0, 1'b1, 32'hDEAD_BEEF, 8'h0F);
        vecs[2] = mk("lsu_load", 1'b1, 32'h8000_3000, 1'b0, 32'h7777_7777, 8'hFF, 1, 2,
                     32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 32'h7777_7777, 8'hFF);
        vecs[3] = mk("ifu_stall_zw", 1'b0, 32'h8000_0010, 1'b0, 32'h0, 8'h00, 2, 0,
                     32'h0010_0073, 32'h0010_0073, 1'b0, 32'h0, 8'h0F);

        rst = 1'b1;
        bus.ifu_req_valid = 1'b0; bus.ifu_addr = '0;
        bus.lsu_req_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
        bus.lsu_wdata = '0; bus.lsu_mask = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        bus.ifu_req_valid = 1'b1;
        #1;
        check("rst_ctrl", 64'({bus.ifu_req_ready, bus.ifu_rsp_valid, bus.ifu_rsp_err,
                               bus.lsu_req_ready, bus.lsu_rsp_valid, bus.lsu_rsp_err,
                               bus.mem_req_valid, bus.mem_wen, bus.mem_abort}), 64'h0);
        check("rst_data", {bus.ifu_rdata, bus.lsu_rdata}, 64'h0);
        check("rst_mem", {bus.mem_addr, bus.mem_wdata}, 64'h0);

        // Round-robin: both requesters held valid from the first free cycle.
        @(negedge clk);
        rst = 1'b0;
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0004;
        bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_2000; bus.lsu_wen = 1'b0;
        bus.lsu_wdata = 32'h1111_1111; bus.lsu_mask = 8'h03;
        for (int g = 0; g < 4; g++) begin
            logic        exp_l;
            logic [31:0] dat;
            exp_l = (g % 2 == 0);
            dat   = exp_l ? (32'hA000_0000 + 32'(g)) : (32'hB000_0000 + 32'(g));
            #1 check($sformatf("rr_grant_%0d", g),
                     64'({bus.lsu_req_ready, bus.ifu_req_ready}), exp_l ? 64'h2 : 64'h1);
            @(negedge clk);
            #1 check($sformatf("rr_busy_ready_%0d", g),
                     64'({bus.lsu_req_ready, bus.ifu_req_ready}), 64'h0);
            check($sformatf("rr_addr_mask_%0d", g), 64'({bus.mem_addr, bus.mem_mask}),
                  exp_l ? 64'({32'h8000_2000, 8'h03}) : 64'({32'h8000_0004, 8'h0F}));
            bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b1; bus.mem_rdata = dat;
            @(negedge clk);
            bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
            if (g == 3) begin
                bus.ifu_req_valid = 1'b0;
                bus.lsu_req_valid = 1'b0;
            end
            if (exp_l) exp_lsu_rdata = dat;
            else       exp_ifu_rdata = dat;
            #1 check($sformatf("rr_rsp_%0d", g),
                     64'({bus.lsu_rsp_valid, bus.ifu_rsp_valid}), exp_l ? 64'h2 : 64'h1);
            check($sformatf("rr_rdata_%0d", g), {bus.ifu_rdata, bus.lsu_rdata},
                  {exp_ifu_rdata, exp_lsu_rdata});
            @(negedge clk);
        end

        for (int i = 0; i < 4; i++) do_txn(vecs[i]);

        // Watchdog: memory takes the request but never answers; a response
        // arriving exactly in the abort cycle must be dropped.
        @(negedge clk);
        bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_4000; bus.lsu_wen = 1'b0;
        bus.lsu_mask = 8'h0F;
        #1 check("to_ready", 64'(bus.lsu_req_ready), 64'h1);
        @(negedge clk);
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1 check("to_req", 64'({bus.mem_abort, bus.mem_req_valid}), 64'h1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            #1 check($sformatf("to_wait_%0d", k), 64'({bus.mem_abort, bus.mem_req_valid}), 64'h0);
        end
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h5555_5555;
        #1 check("to_abort", 64'({bus.mem_abort, bus.mem_req_valid}), 64'h2);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        exp_lsu_rdata = 32'h0;
        #1 check("to_rsp", 64'({bus.mem_abort, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.lsu_rsp_err}),
                 64'h3);
        check("to_rdata", 64'(bus.lsu_rdata), 64'h0);
        @(negedge clk);
        #1 check("to_after", 64'({bus.lsu_rsp_valid, bus.lsu_rsp_err}), 64'h0);
        do_txn(mk("after_to", 1'b1, 32'h8000_5000, 1'b0, 32'h0, 8'h0F, 0, 1,
                  32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0, 32'h0, 8'h0F));

        // Zero-wait memory: response visible two edges after the handshake.
        @(negedge clk);
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0020;
        #1 check("zw_ready", 64'(bus.ifu_req_ready), 64'h1);
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        #1 check("zw_early", 64'(bus.ifu_rsp_valid), 64'h0);
        bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h0000_8067;
        @(negedge clk);
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
        #1 check("zw_latency", 64'({bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.lsu_rsp_valid}), 64'h4);
        check("zw_rdata", 64'(bus.ifu_rdata), 64'h0000_8067);

        // Reset while waiting for memory: no response, a late reply ignored.
        @(negedge clk);
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0040;
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        #1 check("rstw_ctrl", 64'({bus.ifu_req_ready, bus.ifu_rsp_valid, bus.ifu_rsp_err,
                                   bus.lsu_req_ready, bus.lsu_rsp_valid, bus.lsu_rsp_err,
                                   bus.mem_req_valid, bus.mem_abort}), 64'h0);
        check("rstw_data", {bus.ifu_rdata, bus.lsu_rdata}, 64'h0);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        #1 check("rstw_late", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid}), 64'h0);
        @(negedge clk);
        #1 check("rstw_late2", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ysyx_22041211_mem_arbiter
`default_nettype wire
